// File: rtl/od_pkg.sv
// Shared types for the obstacle-detection ultrasonic scheduler.
package od_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_REPORT,
        ST_GAP
    } od_state_e;

    localparam int OD_TIME_W = 23;

    typedef logic [OD_TIME_W-1:0] od_time_t;

    // Returns the index of the first set mask bit at or after 'start',
    // wrapping around within the first 'n' bits.  Bits at or above 'n'
    // are ignored.  Returns 0 when nothing is set; callers check the mask
    // for zero before trusting the result.
    function automatic logic [2:0] od_pick(input logic [7:0] mask,
                                           input logic [2:0] start,
                                           input int         n);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = int'(start) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && mask[idx[2:0]]) begin
                sel   = idx[2:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/od_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module od_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/od_ultrasonic_scheduler.sv
// Round-robin scheduler sharing one echo-width timer among several
// HC-SR04-style sensors; one registered result per slot over valid/ready.
module od_ultrasonic_scheduler
    import od_pkg::*;
#(
    parameter int       NUM_SENSORS = 4,
    parameter int       TRIG_CYCLES = 500,
    parameter int       WAIT_MAX    = 1_500_000,
    parameter od_time_t ECHO_MAX    = 23'h7FFFFF,
    parameter int       GAP_CYCLES  = 3_000_000,
    localparam int      ID_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic [NUM_SENSORS-1:0] i_sensor_mask,
    input  logic [NUM_SENSORS-1:0] i_echo,
    output logic [NUM_SENSORS-1:0] o_trig,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic [ID_W-1:0]        o_result_id,
    output od_time_t               o_result_time,
    output logic                   o_result_timeout,
    output logic                   o_busy
);

    od_state_e r_state;
    od_state_e w_stateNext;

    od_time_t  r_count;
    od_time_t  w_countNext;

    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_idNext;
    logic [ID_W-1:0] r_nextId;
    logic [ID_W-1:0] w_nextIdNext;

    logic [NUM_SENSORS-1:0] w_echoSync;
    logic [NUM_SENSORS-1:0] r_echoDly;
    logic                   w_echoSel;
    logic                   w_echoRise;

    logic [7:0]      w_maskExt;
    logic [2:0]      w_pick;
    logic [ID_W-1:0] w_pickId;
    logic            w_canStart;

    logic [NUM_SENSORS-1:0] r_trig;
    logic [NUM_SENSORS-1:0] w_trigNext;
    logic                   r_valid;
    logic                   r_busy;
    od_time_t               r_resTime;
    od_time_t               w_resTimeNext;
    logic                   r_resTimeout;
    logic                   w_resTimeoutNext;

    od_sync2 #(
        .WIDTH (NUM_SENSORS)
    ) u_echoSync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_echo),
        .o_q   (w_echoSync)
    );

    // Edge detection compares each synced echo against its own delayed copy,
    // so an echo already high when a slot starts never looks like a rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_echoDly <= '0;
        end else begin
            r_echoDly <= w_echoSync;
        end
    end

    assign w_echoSel  = w_echoSync[r_id];
    assign w_echoRise = w_echoSel & ~r_echoDly[r_id];

    assign w_maskExt  = 8'(i_sensor_mask);
    assign w_pick     = od_pick(w_maskExt, 3'(r_nextId), NUM_SENSORS);
    assign w_pickId   = ID_W'(w_pick);
    assign w_canStart = i_enable && (i_sensor_mask != '0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; the single counter times TRIG, WAIT, MEASURE and GAP.
    always_comb begin
        w_stateNext      = r_state;
        w_countNext      = r_count;
        w_idNext         = r_id;
        w_nextIdNext     = r_nextId;
        w_resTimeNext    = r_resTime;
        w_resTimeoutNext = r_resTimeout;
        unique case (r_state)
            ST_IDLE: begin
                if (w_canStart) begin
                    w_idNext    = w_pickId;
                    w_countNext = '0;
                    w_stateNext = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (r_count == od_time_t'(TRIG_CYCLES - 1)) begin
                    w_countNext = '0;
                    w_stateNext = ST_WAIT_ECHO;
                end else begin
                    w_countNext = r_count + od_time_t'(1);
                end
            end
            ST_WAIT_ECHO: begin
                if (w_echoRise) begin
                    w_countNext = od_time_t'(1);
                    w_stateNext = ST_MEASURE;
                end else if (r_count == od_time_t'(WAIT_MAX - 1)) begin
                    w_resTimeNext    = '0;
                    w_resTimeoutNext = 1'b1;
                    w_stateNext      = ST_REPORT;
                end else begin
                    w_countNext = r_count + od_time_t'(1);
                end
            end
            ST_MEASURE: begin
                if (!w_echoSel) begin
                    w_resTimeNext    = r_count;
                    w_resTimeoutNext = 1'b0;
                    w_stateNext      = ST_REPORT;
                end else if (r_count == ECHO_MAX) begin
                    w_resTimeNext    = ECHO_MAX;
                    w_resTimeoutNext = 1'b1;
                    w_stateNext      = ST_REPORT;
                end else begin
                    w_countNext = r_count + od_time_t'(1);
                end
            end
            ST_REPORT: begin
                if (i_result_ready) begin
                    w_countNext  = '0;
                    w_nextIdNext = (r_id == ID_W'(NUM_SENSORS - 1)) ? '0 : r_id + ID_W'(1);
                    w_stateNext  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_count == od_time_t'(GAP_CYCLES - 1)) begin
                    w_countNext = '0;
                    if (w_canStart) begin
                        w_idNext    = w_pickId;
                        w_stateNext = ST_TRIG;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end else begin
                    w_countNext = r_count + od_time_t'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        w_trigNext = (w_stateNext == ST_TRIG) ? (NUM_SENSORS'(1) << w_idNext) : '0;
    end

    // Datapath and output registers, loaded from the next-state decision so
    // every output changes on the same edge as the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= '0;
            r_id         <= '0;
            r_nextId     <= '0;
            r_trig       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_resTime    <= '0;
            r_resTimeout <= 1'b0;
        end else begin
            r_count      <= w_countNext;
            r_id         <= w_idNext;
            r_nextId     <= w_nextIdNext;
            r_trig       <= w_trigNext;
            r_valid      <= (w_stateNext == ST_REPORT);
            r_busy       <= (w_stateNext != ST_IDLE);
            r_resTime    <= w_resTimeNext;
            r_resTimeout <= w_resTimeoutNext;
        end
    end

    assign o_trig           = r_trig;
    assign o_result_valid   = r_valid;
    assign o_result_id      = r_id;
    assign o_result_time    = r_resTime;
    assign o_result_timeout = r_resTimeout;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_od_ultrasonic_scheduler.sv
// Self-checking bench for od_ultrasonic_scheduler with small timing parameters.
module tb_od_ultrasonic_scheduler;

    localparam int NS    = 4;
    localparam int TRIG  = 4;
    localparam int WAITM = 20;
    localparam int ECHOM = 100;
    localparam int GAP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ready;
    logic [3:0]  mask;
    logic [3:0]  echo;
    logic [3:0]  trig;
    logic        valid;
    logic [1:0]  resId;
    logic [22:0] resTime;
    logic        resTimeout;
    logic        busy;

    typedef struct {
        logic [3:0] mask;
        int         delay;
        int         width;
        int         stall;
        int         expId;
        int         expTime;
        int         expTo;
    } vec_t;

    vec_t vecs[9];

    int passCount  = 0;
    int checkCount = 0;
    int cyc        = 0;
    int nextPtr    = 0;
    int echoStart[NS];
    int echoEnd[NS];

    od_ultrasonic_scheduler #(
        .NUM_SENSORS (NS),
        .TRIG_CYCLES (TRIG),
        .WAIT_MAX    (WAITM),
        .ECHO_MAX    (23'(ECHOM)),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (enable),
        .i_sensor_mask    (mask),
        .i_echo           (echo),
        .o_trig           (trig),
        .o_result_valid   (valid),
        .i_result_ready   (ready),
        .o_result_id      (resId),
        .o_result_time    (resTime),
        .o_result_timeout (resTimeout),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checkCount++;
        if (got == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One cycle: step to the falling edge, then drive echoes from the schedule.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int s = 0; s < NS; s++) begin
            echo[s] = (cyc >= echoStart[s]) && (cyc < echoEnd[s]);
        end
    endtask

    // Round-robin reference: first set mask bit at or after the pointer.
    function automatic int pickNext(input logic [3:0] m, input int start);
        for (int i = 0; i < NS; i++) begin
            if (m[(start + i) % NS]) return (start + i) % NS;
        end
        return -1;
    endfunction

    // Expected result for a pulse driven 'delay' cycles after trig falls.
    // The synced rise is seen 3 cycles after the drive cycle (2 sync flops
    // plus the edge compare), and must land inside the WAITM-cycle window.
    function automatic void expectPulse(input int delay, input int width,
                                        output int t, output int to);
        if (width == 0 || delay + 3 > WAITM) begin
            t  = 0;
            to = 1;
        end else if (width > ECHOM) begin
            t  = ECHOM;
            to = 1;
        end else begin
            t  = width;
            to = 0;
        end
    endfunction

    // Runs one full slot: observe the trigger, schedule the echo, take the
    // result (optionally stalling ready) and confirm GAP starts afterwards.
    task automatic applyStimulus(input logic [3:0] m, input int delay, input int width,
                                 input int stall, input int expId, input int expTime,
                                 input int expTo);
        int n;
        int id;
        int hi;
        int fCyc;
        mask  = m;
        ready = (stall == 0);
        n = 0;
        while (trig == 4'b0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("trigStart", int'(trig != 4'b0), 1);
        if (trig == 4'b0) return;
        checkOutput("trigOneHot", $countones(trig), 1);
        id = 0;
        for (int s = 0; s < NS; s++) begin
            if (trig[s]) id = s;
        end
        checkOutput("trigId", id, expId);
        hi = 1;
        n  = 0;
        while (n < 50) begin
            tick();
            n++;
            if (trig != 4'b0) hi++;
            else break;
        end
        checkOutput("trigWidth", hi, TRIG);
        fCyc = cyc;
        if (width > 0) begin
            echoStart[id] = fCyc + delay;
            echoEnd[id]   = fCyc + delay + width;
        end
        n = 0;
        while (!valid && n < 400) begin
            tick();
            n++;
        end
        checkOutput("validRise", int'(valid), 1);
        if (!valid) return;
        checkOutput("resId", int'(resId), expId);
        checkOutput("resTime", int'(resTime), expTime);
        checkOutput("resTimeout", int'(resTimeout), expTo);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("stallValid", int'(valid), 1);
            checkOutput("stallId", int'(resId), expId);
            checkOutput("stallTime", int'(resTime), expTime);
        end
        ready = 1'b1;
        tick();
        checkOutput("gapStartValid", int'(valid), 0);
        checkOutput("gapStartBusy", int'(busy), 1);
        nextPtr = (expId + 1) % NS;
    endtask

    initial begin
        int n;
        int t;
        int to;
        int id;
        int fCyc;
        int sawTrig;
        logic [3:0] m;
        int d;
        int w;
        int st;

        //            mask     dly wid  stall id time to
        vecs[0] = '{4'b1111,   5,  37,  0,   0, 37,  0};
        vecs[1] = '{4'b1111,   5,   0,  0,   1,  0,  1};
        vecs[2] = '{4'b1111,   3, 200,  0,   2, 100, 1};
        vecs[3] = '{4'b1111,  17,  10,  0,   3, 10,  0};
        vecs[4] = '{4'b1111,  18,  10,  0,   0,  0,  1};
        vecs[5] = '{4'b1010,   1,   1,  0,   1,  1,  0};
        vecs[6] = '{4'b1010,   2,  99,  0,   3, 99,  0};
        vecs[7] = '{4'b1010,   4, 101,  0,   1, 100, 1};
        vecs[8] = '{4'b1010,   4,  12, 10,   3, 12,  0};

        for (int s = 0; s < NS; s++) begin
            echoStart[s] = 0;
            echoEnd[s]   = 0;
        end
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        mask   = 4'b0;
        echo   = 4'b0;
        repeat (3) tick();
        checkOutput("rstTrig", int'(trig), 0);
        checkOutput("rstValid", int'(valid), 0);
        checkOutput("rstId", int'(resId), 0);
        checkOutput("rstTime", int'(resTime), 0);
        checkOutput("rstTimeout", int'(resTimeout), 0);
        checkOutput("rstBusy", int'(busy), 0);

        rst  = 1'b0;
        mask = 4'b1111;
        repeat (4) tick();
        checkOutput("disabledTrig", int'(trig), 0);
        checkOutput("disabledBusy", int'(busy), 0);

        enable = 1'b1;
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].mask, vecs[v].delay, vecs[v].width, vecs[v].stall,
                          vecs[v].expId, vecs[v].expTime, vecs[v].expTo);
        end

        // Over-range on sensor 2, then its next slot fires while that echo is
        // still high: the stale level must not start a measurement.
        applyStimulus(4'b0100, 2, 200, 0, 2, 100, 1);
        applyStimulus(4'b0100, 0, 0, 0, 2, 0, 1);

        // Empty mask: the scheduler drops to idle after the current GAP.
        mask = 4'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checkOutput("maskZeroBusy", int'(busy), 0);
        sawTrig = 0;
        repeat (100) begin
            tick();
            if (trig != 4'b0) sawTrig = 1;
        end
        checkOutput("maskZeroTrig", sawTrig, 0);

        // Randomized slots against the reference model.
        for (int r = 0; r < 20; r++) begin
            m  = 4'($urandom_range(1, 15));
            d  = $urandom_range(1, 15);
            w  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 99);
            st = $urandom_range(0, 3);
            expectPulse(d, w, t, to);
            applyStimulus(m, d, w, st, pickNext(m, nextPtr), t, to);
        end

        // Reset in the middle of a measurement.
        mask = 4'b1111;
        n = 0;
        while (trig == 4'b0 && n < 200) begin
            tick();
            n++;
        end
        id = 0;
        for (int s = 0; s < NS; s++) begin
            if (trig[s]) id = s;
        end
        checkOutput("preRstTrigId", id, pickNext(4'b1111, nextPtr));
        n = 0;
        while (trig != 4'b0 && n < 50) begin
            tick();
            n++;
        end
        fCyc = cyc;
        echoStart[id] = fCyc + 2;
        echoEnd[id]   = fCyc + 52;
        repeat (15) tick();
        checkOutput("preRstBusy", int'(busy), 1);
        rst = 1'b1;
        for (int s = 0; s < NS; s++) begin
            echoEnd[s] = 0;
        end
        tick();
        checkOutput("midRstTrig", int'(trig), 0);
        checkOutput("midRstValid", int'(valid), 0);
        checkOutput("midRstId", int'(resId), 0);
        checkOutput("midRstTime", int'(resTime), 0);
        checkOutput("midRstTimeout", int'(resTimeout), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        rst     = 1'b0;
        nextPtr = 0;
        applyStimulus(4'b1111, 5, 20, 0, 0, 20, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
